// File: rtl/button_pkg.sv
// Shared types and board-clock defaults for the push-button reader.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } btn_state_t;

  // Defaults for the 100 MHz board clock: 10 ms debounce, 1 s long press.
  localparam int unsigned DEF_N_BTN           = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_LONG_CYCLES     = 100_000_000;

  function automatic logic is_held(input btn_state_t s);
    return (s == PRESSED) || (s == RELEASE_PEND);
  endfunction

endpackage

// File: rtl/button_reader_if.sv
// Button bank signals: raw pins in, debounced level and event pulses out.
// master = pin/board side, slave = the reader.
interface button_reader_if #(
  parameter int unsigned N_BTN = 4
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;

  modport master (output btn_in, input btn_level, btn_press, btn_release, btn_long);
  modport slave  (input btn_in, output btn_level, btn_press, btn_release, btn_long);
endinterface

// File: rtl/button_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM/counter and long-press counter.
// Long-press logic is built only when BUTTON_READER_LONG_PRESS_EN is defined.
module button_debounce_ch
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned CNT_W = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       blank_q;
  logic             s1_q, s2_q;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, press_q, press_d, release_q, release_d;

  // After reset the pin is ignored for two more edges, so a button held
  // through reset is re-qualified from a clean synchroniser.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q   <= 2'b11;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      blank_q   <= {blank_q[0], 1'b0};
      s1_q      <= blank_q[1] ? 1'b0 : btn_i;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= is_held(state_d);
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      RELEASED: if (s2_q) begin
        state_d = PRESS_PEND;
        cnt_d   = CNT_W'(1);
      end
      PRESS_PEND: begin
        if (!s2_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: if (!s2_q) begin
        state_d = RELEASE_PEND;
        cnt_d   = CNT_W'(1);
      end
      RELEASE_PEND: begin
        if (s2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BUTTON_READER_LONG_PRESS_EN
  localparam int unsigned LONG_W = $clog2(LONG_CYCLES + 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);

  logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
  logic              long_q, long_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      long_q     <= long_d;
    end
  end

  // Saturating one past the firing value is what suppresses repeats.
  always_comb begin
    long_cnt_d = '0;
    long_d     = 1'b0;
    if (is_held(state_q)) begin
      long_cnt_d = (long_cnt_q == LONG_SAT) ? long_cnt_q : long_cnt_q + LONG_W'(1);
      long_d     = (long_cnt_q == LONG_LAST) && is_held(state_d);
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/button_reader.sv
// Debounced push-button bank: N_BTN independent button_debounce_ch channels.
// Define BUTTON_READER_LONG_PRESS_EN to build the long-press pulse logic.
module button_reader
  import button_pkg::*;
#(
  parameter int unsigned N_BTN           = DEF_N_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input logic             clk,
  input logic             rst,
  button_reader_if.slave  btn
);

  if ((DEBOUNCE_CYCLES < 2) || (LONG_CYCLES < 2)) begin : g_bad_params
    $error("button_reader: DEBOUNCE_CYCLES and LONG_CYCLES must both be >= 2");
  end

  logic [N_BTN-1:0] level_w, press_w, release_w, long_w;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn_i     (btn.btn_in[g]),
      .level_o   (level_w[g]),
      .press_o   (press_w[g]),
      .release_o (release_w[g]),
      .long_o    (long_w[g])
    );
  end

  assign btn.btn_level   = level_w;
  assign btn.btn_press   = press_w;
  assign btn.btn_release = release_w;
  assign btn.btn_long    = long_w;

endmodule
